// File: rtl/bitstream_sweep.sv
// Sweep-and-measure engine: steps x over [x_first..x_last] (wrapping) and counts
// ones on each y channel over a 2^LEN_LOG2-cycle window per point.
module bitstream_sweep #(
  parameter int unsigned X_WIDTH         = 8,
  parameter int unsigned LEN_LOG2        = 16,
  parameter int unsigned CHANNELS        = 1,
  parameter int unsigned SETTLE          = 0,
  parameter int unsigned RESET_PER_POINT = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [X_WIDTH-1:0]                 x_first,
  input  logic [X_WIDTH-1:0]                 x_last,
  output logic [X_WIDTH-1:0]                 x,
  output logic                               stream_rst,
  input  logic [CHANNELS-1:0]                y,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [X_WIDTH-1:0]                 res_x,
  output logic [CHANNELS*(LEN_LOG2+1)-1:0]   res_count,
  output logic                               busy,
  output logic                               done
);

  localparam int unsigned CW = LEN_LOG2 + 1;
  localparam int unsigned TW = ((LEN_LOG2 > 8) ? LEN_LOG2 : 8) + 1;
  localparam logic [TW-1:0] COUNT_LAST  = TW'((64'd1 << LEN_LOG2) - 64'd1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'((SETTLE == 0) ? 0 : SETTLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESTART,
    ST_SETTLE,
    ST_COUNT,
    ST_REPORT
  } state_t;

  // First state of every point, and the state that follows the restart pulse.
  localparam state_t AFTER_RESTART = (SETTLE != 0) ? ST_SETTLE : ST_COUNT;
  localparam state_t ENTRY         = (RESET_PER_POINT != 0) ? ST_RESTART : AFTER_RESTART;

  state_t                           state, state_nxt;
  logic [X_WIDTH-1:0]               x_last_q, x_last_nxt;
  logic [X_WIDTH-1:0]               x_nxt, res_x_nxt;
  logic [TW-1:0]                    timer, timer_nxt;
  logic [CHANNELS*CW-1:0]           count_nxt;
  logic                             busy_nxt, done_nxt, res_valid_nxt, stream_rst_nxt;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      x_last_q   <= '0;
      x          <= '0;
      timer      <= '0;
      res_count  <= '0;
      res_x      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      res_valid  <= 1'b0;
      stream_rst <= 1'b0;
    end else begin
      state      <= state_nxt;
      x_last_q   <= x_last_nxt;
      x          <= x_nxt;
      timer      <= timer_nxt;
      res_count  <= count_nxt;
      res_x      <= res_x_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      res_valid  <= res_valid_nxt;
      stream_rst <= stream_rst_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt  = state;
    x_last_nxt = x_last_q;
    x_nxt      = x;
    timer_nxt  = timer;
    count_nxt  = res_count;
    res_x_nxt  = res_x;
    busy_nxt   = busy;
    done_nxt   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          x_nxt      = x_first;
          x_last_nxt = x_last;
          busy_nxt   = 1'b1;
          count_nxt  = '0;
          timer_nxt  = '0;
          state_nxt  = ENTRY;
        end
      end
      ST_RESTART: begin
        timer_nxt = '0;
        state_nxt = AFTER_RESTART;
      end
      ST_SETTLE: begin
        if (timer == SETTLE_LAST) begin
          timer_nxt = '0;
          state_nxt = ST_COUNT;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      ST_COUNT: begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          count_nxt[c*CW +: CW] = res_count[c*CW +: CW] + CW'(y[c]);
        end
        if (timer == COUNT_LAST) begin
          timer_nxt = '0;
          res_x_nxt = x;
          state_nxt = ST_REPORT;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      ST_REPORT: begin
        if (res_ready) begin
          if (x == x_last_q) begin
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            x_nxt     = x + X_WIDTH'(1);
            count_nxt = '0;
            timer_nxt = '0;
            state_nxt = ENTRY;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    stream_rst_nxt = (state_nxt == ST_RESTART);
    res_valid_nxt  = (state_nxt == ST_REPORT);
  end

endmodule

// File: tb/tb_bitstream_sweep.sv
// Directed bench for bitstream_sweep: one instance without settle/restart,
// one with SETTLE=2 and RESET_PER_POINT=1.
module tb_bitstream_sweep;

  logic       clk;
  logic       rst;

  logic       start_a, res_ready_a, stream_rst_a, res_valid_a, busy_a, done_a;
  logic [3:0] x_first_a, x_last_a, x_a, res_x_a;
  logic [1:0] y_a;
  logic [7:0] res_count_a;

  logic       start_b, res_ready_b, stream_rst_b, res_valid_b, busy_b, done_b;
  logic [3:0] x_first_b, x_last_b, x_b, res_x_b;
  logic [1:0] y_b;
  logic [7:0] res_count_b;

  int  errors = 0;
  int  checks = 0;
  bit  toggle_a = 1'b0;

  bitstream_sweep #(.X_WIDTH(4), .LEN_LOG2(3), .CHANNELS(2), .SETTLE(0), .RESET_PER_POINT(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .x_first(x_first_a), .x_last(x_last_a),
    .x(x_a), .stream_rst(stream_rst_a), .y(y_a), .res_valid(res_valid_a),
    .res_ready(res_ready_a), .res_x(res_x_a), .res_count(res_count_a),
    .busy(busy_a), .done(done_a));

  bitstream_sweep #(.X_WIDTH(4), .LEN_LOG2(3), .CHANNELS(2), .SETTLE(2), .RESET_PER_POINT(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .x_first(x_first_b), .x_last(x_last_b),
    .x(x_b), .stream_rst(stream_rst_b), .y(y_b), .res_valid(res_valid_b),
    .res_ready(res_ready_b), .res_x(res_x_b), .res_count(res_count_b),
    .busy(busy_b), .done(done_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Channel 0 is constant 1 or free-running toggle; channel 1 always 0.
  initial begin
    y_a = 2'b01;
    forever begin
      @(negedge clk);
      if (toggle_a) y_a = {1'b0, ~y_a[0]};
      else          y_a = 2'b01;
    end
  end

  // Both channels high for the 3 cycles after each x change (restart + settle).
  initial begin
    int ctr;
    logic [3:0] px;
    logic pb;
    ctr = 100; px = 4'd0; pb = 1'b0; y_b = 2'b00;
    forever begin
      @(negedge clk);
      if (x_b != px || (busy_b && !pb)) ctr = 0;
      else if (ctr < 100) ctr++;
      px = x_b;
      pb = busy_b;
      y_b = (ctr < 3) ? 2'b11 : 2'b00;
    end
  end

  task automatic sweep_a(input logic [3:0] first, input logic [3:0] last, input int npts,
                         input int c0, input int c1, input int stall_at);
    int got, cyc, last_cyc, seen, per;
    logic [3:0] ex, sx;
    logic [7:0] sc;
    x_first_a = first; x_last_a = last; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("busy_start", int'(busy_a), 1);
    check("x_start", int'(x_a), int'(first));
    got = 0; cyc = 0; last_cyc = 0; ex = first;
    while (got < npts && cyc < 1000) begin
      if (res_valid_a) begin
        seen = cyc;
        if (got == stall_at) begin
          res_ready_a = 1'b0;
          sx = res_x_a; sc = res_count_a;
          for (int i = 0; i < 5; i++) begin
            @(negedge clk); cyc++;
            check("stall_valid", int'(res_valid_a), 1);
            check("stall_res_x", int'(res_x_a), int'(sx));
            check("stall_count", int'(res_count_a), int'(sc));
            check("stall_x", int'(x_a), int'(ex));
          end
          res_ready_a = 1'b1;
        end
        check("res_x", int'(res_x_a), int'(ex));
        check("count_ch0", int'(res_count_a[3:0]), c0);
        check("count_ch1", int'(res_count_a[7:4]), c1);
        per = (stall_at >= 0 && got == stall_at + 1) ? 14 : 9;
        if (got == 0) check("first_latency", seen, 8);
        else          check("period", seen - last_cyc, per);
        last_cyc = seen;
        got++;
        ex = ex + 4'd1;
        @(negedge clk); cyc++;
        check("done", int'(done_a), (got == npts) ? 1 : 0);
        check("busy", int'(busy_a), (got == npts) ? 0 : 1);
        check("valid_fall", int'(res_valid_a), 0);
      end else begin
        @(negedge clk); cyc++;
      end
    end
    check("points", got, npts);
    @(negedge clk);
    check("done_one_cycle", int'(done_a), 0);
    check("x_hold", int'(x_a), int'(last));
  endtask

  initial begin
    int got, cyc, pulses, rst_cyc, seen_bad;
    logic [3:0] ex;

    rst = 1'b1;
    start_a = 1'b0; res_ready_a = 1'b1; x_first_a = 4'd0; x_last_a = 4'd0;
    start_b = 1'b0; res_ready_b = 1'b1; x_first_b = 4'd0; x_last_b = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_x", int'(x_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_valid", int'(res_valid_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_stream_rst", int'(stream_rst_b), 0);
    check("rst_count", int'(res_count_a), 0);
    check("rst_res_x", int'(res_x_b), 0);
    repeat (2) @(negedge clk);

    sweep_a(4'd0, 4'd3, 4, 8, 0, -1);
    toggle_a = 1'b1;
    sweep_a(4'd0, 4'd3, 4, 4, 0, -1);
    toggle_a = 1'b0;
    sweep_a(4'd0, 4'd3, 4, 8, 0, 1);
    sweep_a(4'd14, 4'd1, 4, 8, 0, -1);
    sweep_a(4'd5, 4'd5, 1, 8, 0, -1);

    // Abort mid-COUNT of point 2; a start during the sweep must be ignored.
    x_first_a = 4'd0; x_last_a = 4'd3; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int c = 0; c < 13; c++) begin
      if (c == 3) begin x_first_a = 4'd9; start_a = 1'b1; end
      if (c == 4) start_a = 1'b0;
      if (c == 5) check("ignored_start_x", int'(x_a), 0);
      if (c == 8) begin
        check("abort_pt1_valid", int'(res_valid_a), 1);
        check("abort_pt1_res_x", int'(res_x_a), 0);
      end
      @(negedge clk);
    end
    check("abort_pt2_x", int'(x_a), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(busy_a), 0);
    check("abort_valid", int'(res_valid_a), 0);
    check("abort_x", int'(x_a), 0);
    check("abort_done", int'(done_a), 0);
    check("abort_count", int'(res_count_a), 0);
    seen_bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done_a || res_valid_a || busy_a) seen_bad++;
    end
    check("abort_quiet", seen_bad, 0);
    sweep_a(4'd0, 4'd3, 4, 8, 0, -1);

    // Settle + restart-per-point instance.
    x_first_b = 4'd0; x_last_b = 4'd3; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    got = 0; cyc = 0; pulses = 0; rst_cyc = -100; ex = 4'd0;
    while (got < 4 && cyc < 1000) begin
      if (stream_rst_b) begin
        pulses++;
        check("b_stream_rst_x", int'(x_b), int'(ex));
        rst_cyc = cyc;
      end
      if (res_valid_b) begin
        check("b_res_x", int'(res_x_b), int'(ex));
        check("b_count_ch0", int'(res_count_b[3:0]), 0);
        check("b_count_ch1", int'(res_count_b[7:4]), 0);
        check("b_rst_to_result", cyc - rst_cyc, 11);
        got++;
        ex = ex + 4'd1;
      end
      @(negedge clk); cyc++;
    end
    check("b_points", got, 4);
    check("b_pulses", pulses, 4);
    check("b_done", int'(done_b), 1);
    check("b_busy", int'(busy_b), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
